// File: rtl/count_mon_pkg.sv
// ============================================================================
// count_mon_pkg : shared types for the count event monitor
// Revision 1.0
// ============================================================================
`default_nettype none

package count_mon_pkg;

  localparam int CW_DEFAULT = 4;

  // Monitor FSM: NO_PREV until a reference sample has been captured
  typedef enum logic [0:0] {
    ST_NO_PREV = 1'b0,
    ST_TRACK   = 1'b1
  } mon_state_e;

  // EVT_NONE marks "no event this cycle" internally and is never queued
  typedef enum logic [1:0] {
    EVT_NONE = 2'b00,
    EVT_WRAP = 2'b01,
    EVT_SKIP = 2'b10
  } evt_type_e;

  // Event record layout at the default count width: {type, prev, cur}
  typedef struct packed {
    evt_type_e               etype;
    logic [CW_DEFAULT-1:0]   prev;
    logic [CW_DEFAULT-1:0]   cur;
  } evt_rec_t;

  function automatic int evt_width(input int cw);
    return 2 + 2 * cw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, registered storage, no write-to-read bypass
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full  = (r_count == (c_aw + 1)'(DEPTH));
  assign empty = (r_count == '0);

  // A full FIFO still takes a push when the head leaves on the same edge
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Masked so the head reads as zero when nothing is queued
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/count_event_monitor.sv
// ============================================================================
// count_event_monitor : classifies counter samples into WRAP/SKIP events
// Revision 1.0
// ============================================================================
`default_nettype none

module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int CW    = CW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CW-1:0]     count_in,
  input  logic              sample_en,
  input  logic              clr_ovf,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [2*CW+1:0]   evt_data,
  output logic [7:0]        wrap_cnt,
  output logic              ovf
);

  localparam int            c_evt_w   = evt_width(CW);
  localparam logic [CW-1:0] c_cnt_max = '1;

  mon_state_e          r_state;
  mon_state_e          w_state_nxt;
  logic [CW-1:0]       r_prev;
  logic                w_prev_load;
  evt_type_e           w_type;
  logic                w_event;
  logic [c_evt_w-1:0]  w_rec;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_drop;
  logic [7:0]          r_wrap_cnt;
  logic                r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_NO_PREV;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_prev_load) begin
        r_prev <= count_in;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_load = 1'b0;
    w_type      = EVT_NONE;
    case (r_state)
      ST_NO_PREV: begin
        if (sample_en) begin
          w_state_nxt = ST_TRACK;
          w_prev_load = 1'b1;
        end
      end
      ST_TRACK: begin
        if (sample_en) begin
          w_prev_load = 1'b1;
          // Wrap is tested before increment: max+1 aliases to zero in CW bits
          if (count_in == r_prev) begin
            w_type = EVT_NONE;
          end else if ((r_prev == c_cnt_max) && (count_in == '0)) begin
            w_type = EVT_WRAP;
          end else if (count_in == (r_prev + 1'b1)) begin
            w_type = EVT_NONE;
          end else begin
            w_type = EVT_SKIP;
          end
        end
      end
      default: begin
        w_state_nxt = ST_NO_PREV;
      end
    endcase
  end

  assign w_event = (w_type != EVT_NONE);
  assign w_rec   = {w_type, r_prev, count_in};
  assign w_pop   = !w_empty && evt_ready;
  assign w_drop  = w_event && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (c_evt_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_event),
    .push_data (w_rec),
    .pop       (w_pop),
    .pop_data  (evt_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Dropped WRAP events still count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap_cnt <= '0;
    end else if ((w_type == EVT_WRAP) && (r_wrap_cnt != 8'hFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign evt_valid = !w_empty;
  assign wrap_cnt  = r_wrap_cnt;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 Parameter CW, default 4, width of the monitored count.
REQ-002 Parameter DEPTH, default 4, event FIFO entries, power of two, >=2.
REQ-003 Port: clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: count_in  input  CW  count value from the upstream 4-bit counter.
REQ-006 Port: sample_en  input  1  count_in is sampled on this cycle.
REQ-007 Port: clr_ovf  input  1  clears the sticky overflow flag.
REQ-008 Port: evt_valid  output  1  FIFO head holds an event.
REQ-009 Port: evt_ready  input  1  consumer accepts the head event.
REQ-010 Port: evt_data  output  2+2*CW  event record {type, prev, cur}.
REQ-011 Port: wrap_cnt  output  8  saturating count of WRAP events detected.
REQ-012 Port: ovf  output  1  sticky flag, an event was dropped because the FIFO was full.

Function
REQ-013 Two-state FSM: NO_PREV (no reference sample held) and TRACK (prev register valid).
REQ-014 NO_PREV + sample_en: load prev <= count_in, go to TRACK, generate no event.
REQ-015 TRACK + sample_en: classify cur=count_in against prev, then prev <= cur.
- cur == prev: HOLD, no event.
- prev == 2^CW-1 and cur == 0: WRAP event.
- cur == prev+1 (no wrap): no event.
- any other value: SKIP event.
REQ-016 Event type encoding: WRAP = 2'b01, SKIP = 2'b10; 2'b00 and 2'b11 are never emitted.
REQ-017 A detected event is pushed into the FIFO on the same edge that samples cur; evt_valid rises the following cycle at the earliest.
REQ-018 Pop occurs on any edge where evt_valid && evt_ready; evt_data is stable while evt_valid=1 and evt_ready=0.
REQ-019 FIFO order is strict first-in, first-out; occupancy ranges 0..DEPTH.
REQ-020 Full with no pop in the same cycle: drop the new event, set ovf; FIFO contents unchanged.
REQ-021 Full with a simultaneous pop: accept the push; occupancy stays DEPTH; ovf unchanged.
REQ-022 Empty with a push: evt_valid=0 in that cycle; no same-cycle bypass.
REQ-023 wrap_cnt increments on every detected WRAP, including dropped ones, and saturates at 255.
REQ-024 clr_ovf clears ovf; when clr_ovf coincides with a new drop, the set wins.
REQ-025 sample_en=0: prev, FSM state and wrap_cnt hold; FIFO pops still proceed.

Reset
REQ-026 On reset=1 at a clock edge: state=NO_PREV, prev=0, FIFO empty, evt_valid=0, evt_data=0, wrap_cnt=0, ovf=0.
REQ-027 Reset has priority over every other input, including a mid-operation push or pop; pending events are discarded.
REQ-028 The first sample after reset deasserts only establishes the reference value and never produces an event.

Structure
REQ-029 A shared package count_mon_pkg holds: CW default, the event-type enum (WRAP, SKIP), and the packed event record struct.
REQ-030 Event storage lives in one sub-module, sync_fifo (parameters WIDTH, DEPTH), with push/pop/full/empty ports and registered storage.
REQ-031 Classification, the FSM, wrap_cnt and ovf live in count_event_monitor.

Verification
REQ-032 Reset, then sample 14,15,0,1 with evt_ready=1 -> exactly one event {01,4'hF,4'h0}; wrap_cnt=1.
REQ-033 Sample 3,3,4,9 -> no event for the hold or the increment; one SKIP {10,4'h4,4'h9}.
REQ-034 evt_ready=0; generate 5 SKIPs with DEPTH=4 -> 4 events queued in order, 5th dropped, ovf=1; pulse clr_ovf -> ovf=0.
REQ-035 FIFO full, push and pop on the same cycle -> push accepted, head advances, ovf stays 0.
REQ-036 Assert reset while 2 events are queued -> evt_valid=0 next cycle; first new sample yields no event.
REQ-037 Drive 300 wrap sequences -> wrap_cnt saturates at 255.
